victim_buffer: RTL

VICTIM_BUFFER -- requirements
Module: victim_buffer

---
 rtl/victim_buffer_pkg.sv | 8 +
 rtl/victim_buffer_if.sv | 28 ++
 rtl/vb_age_tracker.sv | 46 ++++
 rtl/victim_buffer.sv | 96 +++++++++
 4 files changed

// File: rtl/victim_buffer_pkg.sv
// victim_buffer_pkg: shared types and default sizes for the victim buffer.
package victim_buffer_pkg;
  localparam int VB_WIDTH = 256;
  localparam int VB_DEPTH = 8;
  localparam int VB_TAG_W = 11;
  typedef logic [VB_TAG_W-1:0] lc3b_c_tag;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} vb_state_e;
endpackage

// File: rtl/victim_buffer_if.sv
// victim_buffer_if: lookup, insert and writeback signals between the cache and the victim buffer.
interface victim_buffer_if import victim_buffer_pkg::*; #(
  parameter int WIDTH = VB_WIDTH,
  parameter int TAG_W = VB_TAG_W
);
  logic [TAG_W-1:0] lookup_tag;
  logic hit;
  logic [WIDTH-1:0] hit_data;
  logic hit_dirty;
  logic take;
  logic ins_valid;
  logic ins_ready;
  logic [TAG_W-1:0] ins_tag;
  logic [WIDTH-1:0] ins_data;
  logic ins_dirty;
  logic wb_req;
  logic [TAG_W-1:0] wb_tag;
  logic [WIDTH-1:0] wb_data;
  logic wb_ack;
  modport master (
    output lookup_tag, take, ins_valid, ins_tag, ins_data, ins_dirty, wb_ack,
    input hit, hit_data, hit_dirty, ins_ready, wb_req, wb_tag, wb_data
  );
  modport slave (
    input lookup_tag, take, ins_valid, ins_tag, ins_data, ins_dirty, wb_ack,
    output hit, hit_data, hit_dirty, ins_ready, wb_req, wb_tag, wb_data
  );
endinterface

// File: rtl/vb_age_tracker.sv
// vb_age_tracker: per-entry valid bits and recency ages; ages of valid entries stay 0..n-1.
module vb_age_tracker #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic touch,
  input  logic [AW-1:0] touch_idx,
  input  logic drop,
  input  logic [AW-1:0] drop_idx,
  output logic [DEPTH-1:0] valid,
  output logic [AW-1:0] oldest,
  output logic full
);
  logic [DEPTH-1:0][AW-1:0] age_q, age_d;
  logic [DEPTH-1:0] valid_d;
  logic [AW:0] prev;
  // A drop closes the gap it leaves, then a touch ages everything younger than the slot's old age.
  always_comb begin
    valid_d = valid;
    age_d = age_q;
    oldest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (drop && valid[i] && age_q[i] > age_q[drop_idx]) age_d[i] = age_q[i] - AW'(1);
      if (valid[i] && age_q[i] == AW'(DEPTH-1)) oldest = AW'(i);
    end
    if (drop) valid_d[drop_idx] = 1'b0;
    prev = valid_d[touch_idx] ? {1'b0, age_d[touch_idx]} : (AW+1)'(DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (touch && valid_d[i] && {1'b0, age_d[i]} < prev) age_d[i] = age_d[i] + AW'(1);
    if (touch) begin
      valid_d[touch_idx] = 1'b1;
      age_d[touch_idx] = '0;
    end
  end
  assign full = &valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      age_q <= '0;
    end else begin
      valid <= valid_d;
      age_q <= age_d;
    end
endmodule

// File: rtl/victim_buffer.sv
// victim_buffer: fully associative victim buffer with swap-on-hit and dirty-victim writeback.
module victim_buffer import victim_buffer_pkg::*; #(
  parameter int WIDTH = VB_WIDTH,
  parameter int DEPTH = VB_DEPTH,
  parameter int TAG_W = VB_TAG_W
) (
  input logic clk,
  input logic rst_n,
  victim_buffer_if.slave vb
);
  localparam int AW = $clog2(DEPTH);
  vb_state_e state_q, state_d;
  logic [TAG_W-1:0] tag_q [DEPTH];
  (* ramstyle = "logic" *) logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] dirty_q, valid, hit_vec, ins_vec;
  logic [AW-1:0] hit_idx, ins_idx, free_idx, oldest, victim_q, w_idx;
  logic idle, fill, full, take_eff, accept, spill, write_now, w_dirty, drop;
  logic [TAG_W-1:0] w_tag, ins_tag_q;
  logic [WIDTH-1:0] w_data, ins_data_q;
  logic ins_dirty_q;
  always_comb begin
    hit_vec = '0;
    ins_vec = '0;
    hit_idx = '0;
    ins_idx = '0;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      hit_vec[i] = valid[i] && tag_q[i] == vb.lookup_tag;
      ins_vec[i] = valid[i] && tag_q[i] == vb.ins_tag;
      if (hit_vec[i]) hit_idx = AW'(i);
      if (ins_vec[i]) ins_idx = AW'(i);
      if (!valid[i]) free_idx = AW'(i);
    end
  end
  assign idle = state_q == IDLE;
  assign fill = state_q == FILL;
  assign vb.hit = idle && |hit_vec;
  assign vb.hit_data = vb.hit ? data_q[hit_idx] : '0;
  assign vb.hit_dirty = vb.hit && dirty_q[hit_idx];
  assign vb.ins_ready = idle;
  assign take_eff = vb.take && vb.hit;
  assign accept = vb.ins_valid && idle;
  // Slot priority: same tag, swap with the taken entry, first free, then the oldest.
  assign spill = accept && !(|ins_vec) && !take_eff && full && dirty_q[oldest];
  assign write_now = (accept && !spill) || fill;
  assign w_idx = fill ? victim_q : |ins_vec ? ins_idx : take_eff ? hit_idx : full ? oldest : free_idx;
  assign w_tag = fill ? ins_tag_q : vb.ins_tag;
  assign w_data = fill ? ins_data_q : vb.ins_data;
  assign w_dirty = fill ? ins_dirty_q : vb.ins_dirty | (|ins_vec && dirty_q[ins_idx]);
  assign drop = take_eff && !(write_now && w_idx == hit_idx);
  vb_age_tracker #(.DEPTH(DEPTH)) u_age (
    .clk, .rst_n, .touch(write_now), .touch_idx(w_idx), .drop, .drop_idx(hit_idx),
    .valid, .oldest, .full
  );
  always_comb begin
    state_d = state_q;
    vb.wb_req = 1'b0;
    case (state_q)
      IDLE: state_d = spill ? WRITEBACK : IDLE;
      WRITEBACK: begin
        vb.wb_req = 1'b1;
        state_d = vb.wb_ack ? FILL : WRITEBACK;
      end
      FILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      dirty_q <= '0;
      vb.wb_tag <= '0;
      vb.wb_data <= '0;
    end else begin
      state_q <= state_d;
      if (write_now) dirty_q[w_idx] <= w_dirty;
      if (drop) dirty_q[hit_idx] <= 1'b0;
      if (spill) begin
        vb.wb_tag <= tag_q[oldest];
        vb.wb_data <= data_q[oldest];
      end
    end
  always_ff @(posedge clk) begin
    if (write_now) begin
      tag_q[w_idx] <= w_tag;
      data_q[w_idx] <= w_data;
    end
    if (spill) begin
      victim_q <= oldest;
      ins_tag_q <= vb.ins_tag;
      ins_data_q <= vb.ins_data;
      ins_dirty_q <= vb.ins_dirty;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hit_vec) && $onehot0(ins_vec));
endmodule
